// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes, sweep FSM states and golden ALU functions shared by the ALU, its BIST and benches
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_DIV  = 4'd3;
  localparam logic [3:0] OP_SHL  = 4'd4;
  localparam logic [3:0] OP_SHR  = 4'd5;
  localparam logic [3:0] OP_ROL  = 4'd6;
  localparam logic [3:0] OP_ROR  = 4'd7;
  localparam logic [3:0] OP_AND  = 4'd8;
  localparam logic [3:0] OP_OR   = 4'd9;
  localparam logic [3:0] OP_XOR  = 4'd10;
  localparam logic [3:0] OP_NOR  = 4'd11;
  localparam logic [3:0] OP_NAND = 4'd12;
  localparam logic [3:0] OP_XNOR = 4'd13;
  localparam logic [3:0] OP_GT   = 4'd14;
  localparam logic [3:0] OP_EQ   = 4'd15;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    FINISH = 2'd3
  } sweep_state_t;

  // Division by zero yields 0 here only to keep the result defined; checkers mask it.
  function automatic logic [7:0] alu_golden(input logic [7:0] a, input logic [7:0] b,
                                            input logic [3:0] sel);
    logic [7:0] res;
    case (sel)
      OP_ADD:  res = a + b;
      OP_SUB:  res = a - b;
      OP_MUL:  res = a * b;
      OP_DIV:  res = (b == 8'd0) ? 8'd0 : a / b;
      OP_SHL:  res = {a[6:0], 1'b0};
      OP_SHR:  res = {1'b0, a[7:1]};
      OP_ROL:  res = {a[6:0], a[7]};
      OP_ROR:  res = {a[0], a[7:1]};
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_NOR:  res = ~(a | b);
      OP_NAND: res = ~(a & b);
      OP_XNOR: res = ~(a ^ b);
      OP_GT:   res = {7'd0, a > b};
      OP_EQ:   res = {7'd0, a == b};
      default: res = 8'd0;
    endcase
    return res;
  endfunction

  function automatic logic alu_golden_cout(input logic [7:0] a, input logic [7:0] b);
    return ({1'b0, a} + {1'b0, b}) > 9'd255;
  endfunction

endpackage

// File: rtl/alu_golden_model.sv
// rtl/alu_golden_model.sv - combinational expected result, carry and compare mask for one opcode
module alu_golden_model
  import alu_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [3:0] sel,
  output logic [7:0] exp_out,
  output logic       exp_cout,
  output logic       cmp_mask
);

  assign exp_out  = alu_golden(a, b, sel);
  assign exp_cout = alu_golden_cout(a, b);
  // High when the result compare must be skipped (divide by zero); carry is still checked.
  assign cmp_mask = (sel == OP_DIV) && (b == 8'd0);

endmodule

// File: rtl/alu_sweep_checker.sv
// rtl/alu_sweep_checker.sv - BIST engine sweeping every ALU opcode for one operand pair against a golden model
module alu_sweep_checker
  import alu_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int LAST_SEL      = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] a_in,
  input  logic [7:0] b_in,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [3:0] alu_sel,
  input  logic [7:0] alu_out,
  input  logic       alu_cout,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_count,
  output logic       first_fail_valid,
  output logic [3:0] first_fail_sel
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [3:0] SEL_LAST    = 4'(LAST_SEL);

  sweep_state_t state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [7:0]   alu_a_q, alu_a_d;
  logic [7:0]   alu_b_q, alu_b_d;
  logic [3:0]   alu_sel_q, alu_sel_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         pass_q, pass_d;
  logic [4:0]   err_q, err_d;
  logic         ffv_q, ffv_d;
  logic [3:0]   ffs_q, ffs_d;

  logic [7:0]   exp_out;
  logic         exp_cout;
  logic         cmp_mask;
  logic         mismatch;

  alu_golden_model u_golden (
    .a        (alu_a_q),
    .b        (alu_b_q),
    .sel      (alu_sel_q),
    .exp_out  (exp_out),
    .exp_cout (exp_cout),
    .cmp_mask (cmp_mask)
  );

  assign mismatch = ((alu_out != exp_out) && !cmp_mask) || (alu_cout != exp_cout);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_sel_d = alu_sel_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    pass_d    = pass_q;
    err_d     = err_q;
    ffv_d     = ffv_q;
    ffs_d     = ffs_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          alu_a_d   = a_in;
          alu_b_d   = b_in;
          alu_sel_d = 4'd0;
          err_d     = 5'd0;
          ffv_d     = 1'b0;
          ffs_d     = 4'd0;
          pass_d    = 1'b0;
          cnt_d     = SETTLE_LOAD;
          busy_d    = 1'b1;
          state_d   = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == 4'd0) begin
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      SAMPLE: begin
        if (mismatch) begin
          err_d = err_q + 5'd1;
          if (!ffv_q) begin
            ffv_d = 1'b1;
            ffs_d = alu_sel_q;
          end
        end
        if (alu_sel_q == SEL_LAST) begin
          state_d = FINISH;
        end else begin
          alu_sel_d = alu_sel_q + 4'd1;
          cnt_d     = SETTLE_LOAD;
          state_d   = SETTLE;
        end
      end
      FINISH: begin
        // err_q already includes the last opcode's compare at this point.
        done_d  = 1'b1;
        busy_d  = 1'b0;
        pass_d  = (err_q == 5'd0);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      alu_a_q   <= 8'd0;
      alu_b_q   <= 8'd0;
      alu_sel_q <= 4'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      err_q     <= 5'd0;
      ffv_q     <= 1'b0;
      ffs_q     <= 4'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_sel_q <= alu_sel_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      err_q     <= err_d;
      ffv_q     <= ffv_d;
      ffs_q     <= ffs_d;
    end
  end

  assign alu_a            = alu_a_q;
  assign alu_b            = alu_b_q;
  assign alu_sel          = alu_sel_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign err_count        = err_q;
  assign first_fail_valid = ffv_q;
  assign first_fail_sel   = ffs_q;

endmodule
